// File: rtl/cache_fill_fifo.sv
// cache_fill_fifo: circular BRAM FIFO between loader and cache writer with length-driven drain.
// Define CACHE_FILL_FIFO_CKSUM_EN to add a running 32-bit checksum of delivered words.
module cache_fill_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LEN_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_full,
  input  logic                  len_valid,
  input  logic [LEN_W-1:0]      xfer_len,
  input  logic                  rd_req,
  input  logic                  cache_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   count,
`ifdef CACHE_FILL_FIFO_CKSUM_EN
  output logic [31:0]           cksum,
`endif
  output logic                  overflow
);
  localparam int AW = DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;
  state_t state;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [LEN_W-1:0] remaining;
  logic empty, full;
  (* ram_style = "block" *) logic [DATA_W-1:0] mem [2**AW];
  // Flags come from registered pointers, so a word written this cycle is only readable next cycle.
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_full = full;
  assign count = wr_ptr - rd_ptr;
  always_ff @(posedge clk)
    if (rstn && wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
      remaining <= '0;
      state <= IDLE;
`ifdef CACHE_FILL_FIFO_CKSUM_EN
      cksum <= '0;
`endif
    end else begin
      if (wr_en) begin
        if (full) overflow <= 1'b1;
        else wr_ptr <= wr_ptr + 1'b1;
      end
      rd_valid <= 1'b0;
      case (state)
        IDLE, DONE: if (len_valid) begin
`ifdef CACHE_FILL_FIFO_CKSUM_EN
          cksum <= '0;
`endif
          if (xfer_len == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            remaining <= xfer_len;
            state <= RUN;
            done <= 1'b0;
          end
        end
        RUN: if (rd_req && cache_valid && !empty) begin
          rd_data <= mem[rd_ptr[AW-1:0]];
          rd_valid <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          rd_ptr <= rd_ptr + 1'b1;
          remaining <= remaining - 1'b1;
`ifdef CACHE_FILL_FIFO_CKSUM_EN
          cksum <= cksum + 32'(rd_data);
`endif
          if (remaining == LEN_W'(1)) begin
            state <= DONE;
            done <= 1'b1;
          end else state <= RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_fifo.sv
// tb_cache_fill_fifo: directed stimulus, queue-based reference model checked every cycle.
module tb_cache_fill_fifo;
  localparam int DL = 2;
  localparam int DEPTH = 1 << DL;
  logic clk = 0, rstn = 0, wr_en = 0, len_valid = 0, rd_req = 0, cache_valid = 0;
  logic [31:0] wr_data = 0, xfer_len = 0;
  logic wr_full, rd_valid, done, overflow;
  logic [31:0] rd_data;
  logic [DL:0] count;
`ifdef CACHE_FILL_FIFO_CKSUM_EN
  logic [31:0] cksum;
`endif
  cache_fill_fifo #(.DATA_W(32), .DEPTH_LOG2(DL), .LEN_W(32)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .len_valid(len_valid), .xfer_len(xfer_len), .rd_req(rd_req), .cache_valid(cache_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .count(count),
`ifdef CACHE_FILL_FIFO_CKSUM_EN
    .cksum(cksum),
`endif
    .overflow(overflow));
  always #5 clk = ~clk;
  int passed = 0, total = 0, cyc = 0;
  task automatic check(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask
  // Reference model: contents queue plus transfer progress.
  logic [31:0] mq[$];
  logic [31:0] m_rdd, m_ck;
  bit m_ovf, m_done, m_rdv, mvalid, was_rdv, full_seen;
  int m_rem, m_phase, sz;
  logic [31:0] plog[$];
  int pcyc[$];
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      mq.delete();
      m_ovf = 0; m_done = 0; m_rdv = 0; m_rdd = 0; m_rem = 0; m_phase = 0; m_ck = 0; mvalid = 1;
    end else begin
      sz = mq.size();
      was_rdv = m_rdv;
      m_rdv = 0;
      if (was_rdv) begin
        m_ck += mq[0];
        void'(mq.pop_front());
        m_rem--;
        if (m_rem == 0) begin m_phase = 2; m_done = 1; end
      end else if (m_phase == 1 && rd_req && cache_valid && sz > 0) begin
        m_rdv = 1;
        m_rdd = mq[0];
      end
      if (!was_rdv && m_phase != 1 && len_valid) begin
        m_ck = 0;
        if (xfer_len == 0) begin m_phase = 2; m_done = 1; end
        else begin m_rem = int'(xfer_len); m_phase = 1; m_done = 0; end
      end
      if (wr_en) begin
        if (sz == DEPTH) m_ovf = 1;
        else mq.push_back(wr_data);
      end
    end
  end
  always @(negedge clk) if (mvalid) begin
    check("rd_valid", rd_valid, m_rdv);
    check("rd_data", rd_data, m_rdd);
    check("done", done, m_done);
    check("count", count, mq.size());
    check("wr_full", wr_full, mq.size() == DEPTH);
    check("overflow", overflow, m_ovf);
`ifdef CACHE_FILL_FIFO_CKSUM_EN
    check("cksum", cksum, m_ck);
`endif
    if (rd_valid) begin plog.push_back(rd_data); pcyc.push_back(cyc); end
    if (wr_full) full_seen = 1;
  end
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(logic [31:0] d);
    wr_en = 1; wr_data = d; tick(); wr_en = 0;
  endtask
  task automatic start(int l);
    len_valid = 1; xfer_len = l; tick(); len_valid = 0;
  endtask
  task automatic wait_done(int mx);
    int i = 0;
    while (!done && i < mx) begin tick(); i++; end
    check("done_timeout", done, 1);
  endtask
  task automatic wait_pulses(int n, int mx);
    int i = 0;
    while (plog.size() < n && i < mx) begin tick(); i++; end
    check("pulse_timeout", plog.size() >= n, 1);
  endtask
  task automatic clr();
    plog.delete(); pcyc.delete();
  endtask
  logic [31:0] e1[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] e2[3] = '{32'h55, 32'h66, 32'h77};
  logic [31:0] e3[5] = '{32'ha1, 32'ha2, 32'ha3, 32'ha4, 32'ha5};
  initial begin
    tick(2);
    rstn = 1;
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_full", wr_full, 0);
    check("rst_overflow", overflow, 0);
    // Basic four-word transfer
    clr();
    start(4);
    rd_req = 1; cache_valid = 1;
    for (int i = 0; i < 4; i++) wr(e1[i]);
    wait_done(40);
    check("t1_npulse", plog.size(), 4);
    for (int i = 0; i < 4 && i < plog.size(); i++) check("t1_data", plog[i], e1[i]);
    for (int i = 1; i < 4 && i < pcyc.size(); i++) check("t1_gap", pcyc[i] - pcyc[i-1], 2);
    check("t1_count", count, 0);
    // Writer stall must not end the transfer
    clr();
    start(3);
    wr(e2[0]);
    tick(20);
    check("t2_stall_npulse", plog.size(), 1);
    check("t2_stall_done", done, 0);
    wr(e2[1]); wr(e2[2]);
    wait_done(40);
    check("t2_npulse", plog.size(), 3);
    for (int i = 0; i < 3 && i < plog.size(); i++) check("t2_data", plog[i], e2[i]);
    // Fill to full, drop the fifth word
    clr();
    rd_req = 0;
    for (int i = 0; i < 4; i++) wr(e3[i]);
    check("t3_full", wr_full, 1);
    check("t3_count", count, 4);
    check("t3_ovf_before", overflow, 0);
    wr(e3[4]);
    check("t3_ovf", overflow, 1);
    check("t3_count_after", count, 4);
    start(4);
    rd_req = 1;
    wait_done(40);
    check("t3_npulse", plog.size(), 4);
    for (int i = 0; i < 4 && i < plog.size(); i++) check("t3_data", plog[i], e3[i]);
    check("t3_ovf_sticky", overflow, 1);
    // Ten-word stream with pointer wrap
    clr();
    full_seen = 0;
    start(10);
    for (int i = 0; i < 10; i++) begin wr(32'h100 + i); tick(); end
    wait_done(60);
    check("t4_npulse", plog.size(), 10);
    for (int i = 0; i < 10 && i < plog.size(); i++) check("t4_data", plog[i], 32'h100 + i);
    check("t4_never_full", full_seen, 0);
    // Zero length, then reset mid-transfer
    rstn = 0; tick(); rstn = 1;
    clr();
    start(0);
    check("t5_zero_done", done, 1);
    tick(3);
    check("t5_zero_npulse", plog.size(), 0);
    start(5);
    wr(32'hb1); wr(32'hb2); wr(32'hb3);
    wait_pulses(2, 40);
    rstn = 0; tick(); rstn = 1;
    check("t5_rst_rd_valid", rd_valid, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_overflow", overflow, 0);
    tick(3);
    check("t5_idle_done", done, 0);
`ifdef CACHE_FILL_FIFO_CKSUM_EN
    start(2);
    wr(32'hffffffff); wr(32'h2);
    wait_done(40);
    check("t6_cksum", cksum, 32'h1);
    start(1);
    check("t6_cksum_clr", cksum, 0);
    wr(32'h5);
    wait_done(40);
    check("t6_cksum2", cksum, 32'h5);
`endif
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/cache_fill_fifo.md
Name: cache_fill_fifo

Overview:
- Parametrised successor to the single-shot 4 KB input buffer between the host loader and the cache fill path.
- Circular BRAM FIFO with true full/empty tracking and back-pressure toward the writer.
- Length-driven drain: completion is declared when exactly the programmed number of words has been delivered, not when the FIFO momentarily runs empty.
- Sits between the UART/AXI loader (write side) and the cache writer (read side).

Parameters:
DATA_W, 32, word width in bits
DEPTH_LOG2, 10, log2 of FIFO depth (default 1024 entries, 4 KB at 32 bits)
LEN_W, 32, width of the transfer-length register

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
wr_en  in  1  write strobe from loader
wr_data  in  DATA_W  write word
wr_full  out  1  FIFO full; writes while high are dropped
len_valid  in  1  one-cycle strobe: load xfer_len and start a transfer
xfer_len  in  LEN_W  number of words to deliver in this transfer
rd_req  in  1  cache writer requests data
cache_valid  in  1  previous cache write accepted
rd_data  out  DATA_W  word to cache
rd_valid  out  1  one-cycle pulse, rd_data valid
done  out  1  transfer complete (level)
count  out  DEPTH_LOG2+1  current occupancy
overflow  out  1  sticky: a write was dropped while full

Behaviour:
- Reset (rstn=0 at posedge): wr/rd pointers=0, count=0, wr_full=0, rd_valid=0, rd_data=0, done=0, overflow=0, remaining=0, state=IDLE. Reset has priority over every other input; a transfer in progress is abandoned and FIFO contents are discarded.
- Pointers are DEPTH_LOG2+1 bits.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Wrap-around is natural modulo 2^(DEPTH_LOG2+1).
- count = wr_ptr - rd_ptr, registered. Max value is 2^DEPTH_LOG2.
- Write side:
  - wr_en && !wr_full: store at wr_ptr[DEPTH_LOG2-1:0]; wr_ptr+1.
  - wr_en && wr_full: drop the word and set overflow. overflow clears only on reset.
  - Writes are accepted in every state, including DONE.
- Read state machine:
  - IDLE:
    - len_valid && xfer_len==0: go to DONE, done=1 next cycle.
    - len_valid && xfer_len!=0: remaining=xfer_len, go to RUN.
  - RUN:
    - If rd_req && cache_valid && !empty: issue BRAM read at rd_ptr, go to WAIT.
    - Empty FIFO while remaining>0 is a stall, not completion.
  - WAIT:
    - Exactly one cycle. Assert rd_valid=1 with the BRAM output.
    - rd_ptr+1, remaining-1.
    - remaining becomes 0: go to DONE. Otherwise: go to RUN.
  - DONE:
    - done=1 held.
    - len_valid: go to IDLE handling with the new length (done drops the cycle after), i.e. back-to-back transfers.
  - len_valid in RUN/WAIT is ignored.
- Throughput and latency:
  - At most one outstanding read; maximum throughput is one word per 2 cycles.
  - Latency is rd_req&&cache_valid sampled -> rd_valid 1 cycle later.
- Simultaneous write and read:
  - Both pointers update in the same cycle; count is unchanged.
  - A word written in cycle N is readable no earlier than cycle N+1, because empty is evaluated on registered pointers.
  - No read-during-write hazard on the same address can occur.
- Full flag:
  - wr_full is derived from registered pointers.
  - A read completing in the same cycle as a write at full does not rescue that write; the write is dropped.
- rd_data holds its value between pulses.
- BRAM is inferred with ram_style BLOCK and a registered read.

Optional Feature:
- Macro: CACHE_FILL_FIFO_CKSUM_EN.
- Defined:
  - Adds output port cksum (32 bits): running modulo-2^32 sum of every word delivered with rd_valid, zero-extended or truncated to 32 bits.
  - cksum is cleared on reset and on accepted len_valid.
  - cksum is valid when done=1.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then len_valid with xfer_len=4; write 0x11,0x22,0x33,0x44; hold rd_req=cache_valid=1 -> four rd_valid pulses 2 cycles apart carrying 0x11..0x44 in order; done=1 after the 4th; count returns to 0.
- xfer_len=3; write 1 word, then stall writer 20 cycles -> exactly one rd_valid, done stays 0 through the stall; write 2 more words -> two more pulses, then done=1.
- DEPTH_LOG2=2: write 5 words with no reads -> wr_full=1 after 4th, count=4, 5th dropped, overflow=1; drain 4 -> data equals first 4 words; overflow remains 1.
- DEPTH_LOG2=2: stream 10 words with concurrent reads, xfer_len=10 -> pointers wrap twice, all 10 delivered in order, wr_full never 1 if writer rate is at most the read rate.
- xfer_len=0 -> done=1 one cycle after len_valid with no rd_valid; assert rstn=0 mid-transfer (after 2 of 5 words) -> next cycle rd_valid=0, done=0, count=0, state IDLE.
- With CACHE_FILL_FIFO_CKSUM_EN: words 0xFFFFFFFF,0x00000002 -> cksum=0x00000001 at done; second transfer clears cksum on len_valid.
